// File: rtl/cp0_ctrl.sv
// Coprocessor-0 controller: Status/Cause/EPC/BadVAddr, Count/Compare timer,
// hardware interrupt sync/masking, exception entry and ERET sequencing.
module cp0_ctrl #(
  parameter int                DATA_W     = 32,
  parameter int                NUM_IRQ    = 5,
  parameter int                COUNT_DIV  = 1,
  parameter logic [DATA_W-1:0] EXC_VECTOR = DATA_W'(32'h8000_0180)
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               mtc0,
  input  logic [4:0]         w_Addr,
  input  logic [DATA_W-1:0]  d_in,
  input  logic [4:0]         rd_Addr,
  input  logic [NUM_IRQ-1:0] hw_irq,
  input  logic               exc_valid,
  input  logic [4:0]         exc_code,
  input  logic [DATA_W-1:0]  exc_pc,
  input  logic               exc_bad_v,
  input  logic [DATA_W-1:0]  exc_badvaddr,
  input  logic               eret,
  output logic [DATA_W-1:0]  C0,
  output logic [DATA_W-1:0]  epc_out,
  output logic               irq_req,
  output logic               exl_out,
  output logic [DATA_W-1:0]  exc_vector
);

  localparam int              PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(COUNT_DIV - 1);
  localparam logic [7:0]      IM_WMASK  = 8'h83 | 8'(((1 << NUM_IRQ) - 1) << 2);

  localparam logic [4:0] A_BADV    = 5'd8;
  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  logic [DATA_W-1:0]  badvaddr;
  logic [DATA_W-1:0]  count;
  logic [DATA_W-1:0]  compare;
  logic [DATA_W-1:0]  epc;
  logic [PW-1:0]      presc;
  logic               ie;
  logic               exl;
  logic               ti;
  logic [7:0]         im;
  logic [4:0]         excode;
  logic [1:0]         ip_sw;
  logic [NUM_IRQ-1:0] ip_hw;

  logic [7:0] ip;
  logic       tick;
  logic       cnt_wr;
  logic       cmp_wr;
  logic       st_wr;
  logic       cause_wr;
  logic       epc_wr;

  always_comb begin
    ip       = {ti, 5'(ip_hw), ip_sw};
    tick     = (presc == PRESC_MAX);
    cnt_wr   = mtc0 && (w_Addr == A_COUNT);
    cmp_wr   = mtc0 && (w_Addr == A_COMPARE);
    st_wr    = mtc0 && (w_Addr == A_STATUS);
    cause_wr = mtc0 && (w_Addr == A_CAUSE);
    epc_wr   = mtc0 && (w_Addr == A_EPC);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      badvaddr <= '0;
      count    <= '0;
      compare  <= '0;
      epc      <= '0;
      presc    <= '0;
      ie       <= 1'b0;
      exl      <= 1'b0;
      ti       <= 1'b0;
      im       <= '0;
      excode   <= '0;
      ip_sw    <= '0;
      ip_hw    <= '0;
    end else begin
      ip_hw <= hw_irq;

      // A Count load suppresses this cycle's increment, so it cannot raise TI.
      if (cnt_wr) begin
        count <= d_in;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) count <= count + 1'b1;
      end

      if (cmp_wr) begin
        compare <= d_in;
        ti      <= 1'b0;
      end else if (tick && !cnt_wr && (count == compare)) begin
        ti <= 1'b1;
      end

      if (st_wr) begin
        ie <= d_in[0];
        im <= d_in[15:8] & IM_WMASK;
      end
      if (cause_wr) ip_sw <= d_in[9:8];

      // Exception entry owns EXL/EPC; EPC is frozen while already in EXL.
      if (exc_valid) begin
        excode <= exc_code;
        exl    <= 1'b1;
        if (!exl) epc <= exc_pc;
        if (exc_bad_v) badvaddr <= exc_badvaddr;
      end else begin
        if (eret) exl <= 1'b0;
        else if (st_wr) exl <= d_in[1];
        if (epc_wr) epc <= d_in;
      end
    end
  end

  always_comb begin
    C0 = '0;
    case (rd_Addr)
      A_BADV:    C0 = badvaddr;
      A_COUNT:   C0 = count;
      A_COMPARE: C0 = compare;
      A_STATUS:  C0 = DATA_W'({im, 6'b0, exl, ie});
      A_CAUSE:   C0 = DATA_W'({1'b0, ti, 14'b0, ip, 1'b0, excode, 2'b00});
      A_EPC:     C0 = epc;
      default:   C0 = '0;
    endcase
  end

  assign irq_req    = ie & ~exl & |(ip & im);
  assign epc_out    = epc;
  assign exl_out    = exl;
  assign exc_vector = EXC_VECTOR;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Bench for cp0_ctrl: two instances (COUNT_DIV=1/NUM_IRQ=5 and COUNT_DIV=4/NUM_IRQ=3)
// driven in lockstep and compared against a rule-level reference model.
`timescale 1ns/1ps
module tb_cp0_ctrl;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst;
  logic        mtc0;
  logic [4:0]  w_Addr;
  logic [31:0] d_in;
  logic [4:0]  rd_Addr;
  logic [4:0]  hw_irq;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bad_v;
  logic [31:0] exc_badvaddr;
  logic        eret;

  logic [31:0] c0_0, c0_1, epc_0, epc_1, vec_0, vec_1;
  logic        irq_0, irq_1, exl_0, exl_1;

  cp0_ctrl u_dut0 (
    .CLK(CLK), .rst(rst), .mtc0(mtc0), .w_Addr(w_Addr), .d_in(d_in),
    .rd_Addr(rd_Addr), .hw_irq(hw_irq), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bad_v(exc_bad_v),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .C0(c0_0), .epc_out(epc_0),
    .irq_req(irq_0), .exl_out(exl_0), .exc_vector(vec_0)
  );

  cp0_ctrl #(.NUM_IRQ(3), .COUNT_DIV(4)) u_dut1 (
    .CLK(CLK), .rst(rst), .mtc0(mtc0), .w_Addr(w_Addr), .d_in(d_in),
    .rd_Addr(rd_Addr), .hw_irq(hw_irq[2:0]), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_bad_v(exc_bad_v),
    .exc_badvaddr(exc_badvaddr), .eret(eret), .C0(c0_1), .epc_out(epc_1),
    .irq_req(irq_1), .exl_out(exl_1), .exc_vector(vec_1)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] count, compare, epc, badv;
    int          presc;
    logic        ie, exl, ti;
    logic [7:0]  im;
    logic [4:0]  code;
    logic [1:0]  ipsw;
    logic [4:0]  hw;
  } cp0_t;

  cp0_t m [2];
  int   div_k  [2] = '{1, 4};
  int   nirq_k [2] = '{5, 3};

  task automatic model_step(input int k);
    cp0_t o, n;
    logic tk, cnt_w, st_w;
    o = m[k];
    n = o;
    tk = 1'b0;
    cnt_w = mtc0 && (w_Addr == 5'd9);
    st_w  = mtc0 && (w_Addr == 5'd12);
    if (rst) begin
      n = '{default: 0};
    end else begin
      n.hw = hw_irq & 5'((1 << nirq_k[k]) - 1);
      if (cnt_w) begin
        n.count = d_in;
        n.presc = 0;
      end else begin
        tk = (o.presc == div_k[k] - 1);
        n.presc = tk ? 0 : o.presc + 1;
        if (tk) n.count = o.count + 32'd1;
      end
      if (mtc0 && w_Addr == 5'd11) begin
        n.compare = d_in;
        n.ti = 1'b0;
      end else if (tk && o.count == o.compare) begin
        n.ti = 1'b1;
      end
      if (st_w) begin
        n.ie = d_in[0];
        n.im = d_in[15:8] & (8'h83 | 8'(((1 << nirq_k[k]) - 1) << 2));
      end
      if (mtc0 && w_Addr == 5'd13) n.ipsw = d_in[9:8];
      if (exc_valid) begin
        n.code = exc_code;
        n.exl  = 1'b1;
        if (!o.exl) n.epc = exc_pc;
        if (exc_bad_v) n.badv = exc_badvaddr;
      end else begin
        if (eret) n.exl = 1'b0;
        else if (st_w) n.exl = d_in[1];
        if (mtc0 && w_Addr == 5'd14) n.epc = d_in;
      end
    end
    m[k] = n;
  endtask

  function automatic logic [7:0] model_ip(input int k);
    return {m[k].ti, m[k].hw, m[k].ipsw};
  endfunction

  function automatic logic [31:0] model_read(input int k, input logic [4:0] a);
    case (a)
      5'd8:    return m[k].badv;
      5'd9:    return m[k].count;
      5'd11:   return m[k].compare;
      5'd12:   return {16'b0, m[k].im, 6'b0, m[k].exl, m[k].ie};
      5'd13:   return {1'b0, m[k].ti, 14'b0, model_ip(k), 1'b0, m[k].code, 2'b00};
      5'd14:   return m[k].epc;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq(input int k);
    return m[k].ie & ~m[k].exl & |(model_ip(k) & m[k].im);
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    logic [31:0] e;
    exp_q.push_back(exp);
    e = exp_q.pop_front();
    n_total++;
    assert (obs === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_in();
    mtc0 = 0; w_Addr = 0; d_in = 0; hw_irq = 0; exc_valid = 0; exc_code = 0;
    exc_pc = 0; exc_bad_v = 0; exc_badvaddr = 0; eret = 0;
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [4:0] a);
    rd_Addr = a;
    #0.5;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1; w_Addr = a; d_in = d;
    tick();
    mtc0 = 0;
  endtask

  task automatic check_reads(input string tag);
    logic [4:0] addrs [7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'($urandom_range(0, 7))};
    foreach (addrs[i]) begin
      rd(addrs[i]);
      chk($sformatf("%s/c0_div1[%0d]", tag, addrs[i]), c0_0, model_read(0, addrs[i]));
      chk($sformatf("%s/c0_div4[%0d]", tag, addrs[i]), c0_1, model_read(1, addrs[i]));
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "/epc0"}, epc_0, m[0].epc);
    chk({tag, "/epc1"}, epc_1, m[1].epc);
    chk({tag, "/irq0"}, 32'(irq_0), 32'(model_irq(0)));
    chk({tag, "/irq1"}, 32'(irq_1), 32'(model_irq(1)));
    chk({tag, "/exl0"}, 32'(exl_0), 32'(m[0].exl));
    chk({tag, "/exl1"}, 32'(exl_1), 32'(m[1].exl));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    m[0] = '{default: 0};
    m[1] = '{default: 0};
    rd_Addr = 0;
    clear_in();
    rst = 1;
    tick();
    tick();
    check_reads("reset");
    check_outs("reset");
    chk("exc_vector", vec_0, 32'h8000_0180);

    // Count tracks cycles after reset release
    rst = 0;
    tick();
    tick();
    rd(5'd9);
    chk("count_after_rst", c0_0, 32'd2);
    chk("irq_after_rst", 32'(irq_0), 32'd0);

    // Hardware interrupt through the sync flop, then exception entry
    mtc0 = 1; w_Addr = 5'd12; d_in = 32'h0000_0401; hw_irq = 5'b00001;
    tick();
    mtc0 = 0;
    rd(5'd13);
    chk("ip2_set", 32'(c0_0[10]), 32'd1);
    chk("irq_hw", 32'(irq_0), 32'd1);
    check_outs("irq_hw");
    exc_valid = 1; exc_code = 5'd0; exc_pc = 32'h0040_0020;
    tick();
    exc_valid = 0; hw_irq = 0;
    chk("epc_entry", epc_0, 32'h0040_0020);
    chk("exl_entry", 32'(exl_0), 32'd1);
    chk("irq_masked_exl", 32'(irq_0), 32'd0);
    check_reads("entry");

    // Nested exception holds EPC, records code and BadVAddr
    exc_valid = 1; exc_code = 5'd12; exc_pc = 32'h0040_0100;
    exc_bad_v = 1; exc_badvaddr = 32'hDEAD_BEEC;
    tick();
    clear_in();
    chk("epc_nested", epc_0, 32'h0040_0020);
    rd(5'd13);
    chk("excode_nested", 32'(c0_0[6:2]), 32'd12);
    rd(5'd8);
    chk("badvaddr", c0_0, 32'hDEAD_BEEC);
    eret = 1;
    tick();
    eret = 0;
    chk("exl_eret", 32'(exl_0), 32'd0);
    check_outs("eret");

    // Timer with prescaler
    write_reg(5'd9, 32'd0);
    write_reg(5'd11, 32'd3);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_reads($sformatf("timer%0d", i));
    end
    rd(5'd13);
    chk("ti_div4", 32'(c0_1[30]), 32'd1);
    chk("ip7_div4", 32'(c0_1[15]), 32'd1);
    chk("ti_div1", 32'(c0_0[30]), 32'd1);
    write_reg(5'd11, 32'd100);
    rd(5'd13);
    chk("ti_clr_div1", 32'(c0_0[30]), 32'd0);
    chk("ti_clr_div4", 32'(c0_1[30]), 32'd0);

    // Count wrap and load-over-increment
    write_reg(5'd9, 32'hFFFF_FFFF);
    rd(5'd9);
    chk("count_load", c0_0, 32'hFFFF_FFFF);
    tick();
    rd(5'd9);
    chk("count_wrap", c0_0, 32'd0);
    write_reg(5'd9, 32'h0000_1234);
    rd(5'd9);
    chk("count_load_wins", c0_0, 32'h0000_1234);

    // Exception + ERET + Status write in one cycle
    write_reg(5'd12, 32'h0000_0001);
    mtc0 = 1; w_Addr = 5'd12; d_in = 32'h0;
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h0040_0200; eret = 1;
    tick();
    clear_in();
    chk("exl_prio", 32'(exl_0), 32'd1);
    rd(5'd12);
    chk("ie_prio", 32'(c0_0[0]), 32'd0);
    chk("epc_prio", epc_0, 32'h0040_0200);
    check_outs("prio");

    // Reset mid-sequence
    rst = 1;
    tick();
    rst = 0;
    chk("epc_rst2", epc_0, 32'd0);
    rd(5'd12);
    chk("status_rst2", c0_0, 32'd0);
    check_reads("reset2");
    check_outs("reset2");

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wa;
      rst = ($urandom_range(0, 99) == 0);
      exc_valid = ($urandom_range(0, 9) == 0);
      eret = ($urandom_range(0, 7) == 0);
      exc_code = 5'($urandom);
      exc_pc = $urandom;
      exc_bad_v = 1'($urandom);
      exc_badvaddr = $urandom;
      hw_irq = 5'($urandom);
      mtc0 = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 6))
        0: wa = 5'd8;
        1: wa = 5'd9;
        2: wa = 5'd11;
        3: wa = 5'd12;
        4: wa = 5'd13;
        5: wa = exc_valid ? 5'd12 : 5'd14;
        default: wa = 5'($urandom_range(0, 7));
      endcase
      w_Addr = wa;
      d_in = (wa == 5'd9 || wa == 5'd11) ? 32'($urandom_range(0, 40)) : $urandom;
      tick();
      check_reads($sformatf("rnd%0d", i));
      check_outs($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
Name: cp0_ctrl

Overview:
Parametrised coprocessor-0 controller for the pipelined MIPS core. It supersedes the fixed Cause/EPC-only register file and adds:
- Status with interrupt enable, EXL and mask bits
- BadVAddr
- Count/Compare timer with prescaler
- hardware interrupt pending/masking
- exception entry and ERET sequencing

It sits beside the ID/EX stages, receives mtc0 writes and exception/ERET events from the hazard/exception unit, and supplies mfc0 read data, EPC and an interrupt request.

Parameters:
DATA_W, 32, register/data width (must be >= 16)
NUM_IRQ, 5, hardware interrupt lines, 1..5, mapped to Cause.IP[2+i]
COUNT_DIV, 1, Count increments once every COUNT_DIV cycles (>= 1)
EXC_VECTOR, 32'h8000_0180, constant driven on exc_vector

Ports:
CLK  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
mtc0  in  1  write strobe for CP0 register w_Addr
w_Addr  in  5  mtc0 target register number
d_in  in  DATA_W  mtc0 write data
rd_Addr  in  5  mfc0 source register number
hw_irq  in  NUM_IRQ  level-sensitive external interrupt lines
exc_valid  in  1  exception/interrupt commit this cycle
exc_code  in  5  ExcCode for committed exception (0 = interrupt)
exc_pc  in  DATA_W  PC of faulting/interrupted instruction
exc_bad_v  in  1  exc_badvaddr is meaningful
exc_badvaddr  in  DATA_W  faulting address
eret  in  1  ERET commit
C0  out  DATA_W  combinational read data of rd_Addr
epc_out  out  DATA_W  current EPC
irq_req  out  1  combinational interrupt request to exception unit
exl_out  out  1  Status.EXL
exc_vector  out  DATA_W  EXC_VECTOR

Behaviour:
Register map:
- 8 BadVAddr
- 9 Count
- 11 Compare
- 12 Status: bit0 IE, bit1 EXL, bits[15:8] IM
- 13 Cause: bits[6:2] ExcCode, bits[15:8] IP, bit30 TI
- 14 EPC
- All other addresses read 0; writes to them are ignored. Unimplemented bits read 0.

Reset (rst=1 at edge): every register is 0, prescaler is 0 and hw_irq sync flops are 0. Resulting output values:
- C0 = 0 for any implemented address
- epc_out = 0
- irq_req = 0
- exl_out = 0

IP mapping:
- IP[1:0]: software bits, written only via mtc0 to Cause.
- IP[2+i]: hw_irq[i] through one sync flop, so it appears 1 cycle after the input.
- IP[7]: equals TI.
- Unused IP bits are 0.

irq_req = IE & ~EXL & |(IP & IM). It is combinational from registered state.

Timer:
- Prescaler counts 0..COUNT_DIV-1; Count increments modulo 2^DATA_W when the prescaler wraps.
- When Count == Compare and an increment occurs, TI sets on the next edge (sticky).
- An mtc0 to Compare clears TI and the clear wins over a same-cycle match.
- An mtc0 to Count loads d_in, wins over the increment, and resets the prescaler.

Per-cycle priority, highest first: rst > exc_valid > eret > mtc0. A lower-priority event is dropped only for the fields the higher one writes.

exc_valid:
- Cause.ExcCode <= exc_code.
- If EXL == 0: EPC <= exc_pc.
- If EXL == 1: EPC is held (nested exception).
- EXL <= 1.
- If exc_bad_v: BadVAddr <= exc_badvaddr.
- exc_valid and eret together: exception wins and eret is ignored.

eret: EXL <= 0. epc_out already presents the return target.

mtc0 writes:
- Status: IE, EXL and IM[1:0] take d_in. IM[2+i] takes d_in only for implemented lines. IM[7] is writable.
- Cause: only IP[1:0] is writable.
- mtc0 to Status in the same cycle as exc_valid: exc_valid owns EXL, and mtc0 still updates IE and IM.

Read/write interaction: C0 reflects pre-edge state. A same-cycle write is visible in the next cycle (no bypass).

Test Plan:
- Reset, then read each address 8/9/11/12/13/14 -> C0 = 0 at every address except Count; Count reads the cycle count elapsed since reset deassertion (COUNT_DIV=1), irq_req = 0.
- mtc0 Status=32'h0000_0401, hw_irq[0]=1 -> IP[2] set 1 cycle later, irq_req = 1; exc_valid code=0, exc_pc=32'h0040_0020 -> EPC = 32'h0040_0020, EXL = 1, irq_req = 0.
- Nested: with EXL=1, exc_valid code=12, exc_pc=32'h0040_0100, exc_bad_v=1, addr=32'hDEAD_BEEC -> EPC still 32'h0040_0020, ExcCode = 12, BadVAddr = 32'hDEAD_BEEC; eret -> EXL = 0.
- Timer (COUNT_DIV=4): mtc0 Count=0, Compare=3 -> TI set after the 4th increment (≈16 cycles) and IP7 = 1; mtc0 Compare=100 -> TI = 0 next cycle.
- Count wrap: mtc0 Count=32'hFFFF_FFFF -> next increment gives 0; mtc0 Count and the increment in the same cycle -> loaded value wins.
- Same-cycle exc_valid + eret + mtc0 Status=32'h0 -> EXL = 1, IE = 0; reset asserted mid-sequence -> all registers 0 next cycle.
